// File: rtl/instr_encoder.sv
// Packs decoded instruction field tuples into 32-bit words and streams them
// into instruction memory through a registered write port.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_I,
  input  logic              in_S,
  input  logic [5:0]        in_opcode,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic              in_shift,
  input  logic [4:0]        in_shift_imm,
  input  logic [15:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_count,
  output logic [ADDR_W-1:0] written_count
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remaining_reg;
  logic [ADDR_W-1:0] err_count_reg;
  logic [ADDR_W-1:0] written_count_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic              wr_en_reg;
  logic              err_reg;

  logic        transfer;
  logic        illegal;
  logic [31:0] packed_word;

  always_comb begin
    packed_word        = '0;
    packed_word[31]    = in_I;
    packed_word[30]    = in_S;
    packed_word[29:24] = in_opcode;
    packed_word[23:20] = in_rn;
    if (in_opcode[5:4] == 2'b00) packed_word[19:16] = in_rd;
    if (in_I) packed_word[15:0] = in_imm;
    else      packed_word[15:0] = {in_shift, in_shift_imm, 6'b000000, in_rm};
  end

  // Non-ALU ops reuse the rd field for rn, and memory ops cannot set flags.
  assign illegal = ((in_opcode[5:4] != 2'b00) && (in_rd != in_rn)) ||
                   ((in_opcode[5:4] == 2'b11) && in_S);

  assign transfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_instr != '0) ? LOAD : DONE;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = (remaining_reg != '0);
        if (remaining_reg == '0 || (transfer && remaining_reg == ONE))
          state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg          <= '0;
      remaining_reg     <= '0;
      err_count_reg     <= '0;
      written_count_reg <= '0;
      wr_addr_reg       <= '0;
      wr_data_reg       <= '0;
      wr_en_reg         <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      if (wr_en_reg) written_count_reg <= written_count_reg + ONE;
      if (state_reg == IDLE && start) begin
        addr_reg          <= base_addr;
        remaining_reg     <= num_instr;
        err_reg           <= 1'b0;
        err_count_reg     <= '0;
        written_count_reg <= '0;
      end
      if (transfer) begin
        remaining_reg <= remaining_reg - ONE;
        if (illegal) begin
          err_reg       <= 1'b1;
          err_count_reg <= err_count_reg + ONE;
        end else begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= addr_reg;
          wr_data_reg <= packed_word;
          addr_reg    <= addr_reg + ONE;
        end
      end
    end
  end

  assign wr_en         = wr_en_reg;
  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign err           = err_reg;
  assign err_count     = err_count_reg;
  assign written_count = written_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes go into a scoreboard queue
// and a negedge monitor pops and compares every wr_en cycle.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  num_instr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_I = 1'b0;
  logic        in_S = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [3:0]  in_rn = '0;
  logic [3:0]  in_rd = '0;
  logic [3:0]  in_rm = '0;
  logic        in_shift = 1'b0;
  logic [4:0]  in_shift_imm = '0;
  logic [15:0] in_imm = '0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_count;
  logic [7:0]  written_count;

  int n_asserts = 0;
  int n_fail = 0;
  logic [39:0] sb_q[$];

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
    .in_I(in_I), .in_S(in_S), .in_opcode(in_opcode), .in_rn(in_rn),
    .in_rd(in_rd), .in_rm(in_rm), .in_shift(in_shift),
    .in_shift_imm(in_shift_imm), .in_imm(in_imm), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .err_count(err_count), .written_count(written_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_asserts++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", wr_addr, wr_data);
      end
      if (sb_q.size() != 0) begin
        logic [39:0] e;
        e = sb_q.pop_front();
        $display("write addr=%0h data=%08h (expect addr=%0h data=%08h)", wr_addr, wr_data, e[39:32], e[31:0]);
        n_asserts++;
        assert ({wr_addr, wr_data} === e) else begin
          n_fail++;
          $error("FAIL write_match: observed %0h/%08h expected %0h/%08h", wr_addr, wr_data, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] n);
    start = 1'b1; base_addr = b; num_instr = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic drive(input logic i, input logic s, input logic [5:0] op,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                       input logic sh, input logic [4:0] shi, input logic [15:0] imm);
    in_I = i; in_S = s; in_opcode = op; in_rn = rn; in_rd = rd; in_rm = rm;
    in_shift = sh; in_shift_imm = shi; in_imm = imm; in_valid = 1'b1;
  endtask

  // Waits (bounded) for in_ready, then lets one transfer happen.
  task automatic xfer();
    int k;
    for (k = 0; k < 20 && !in_ready; k++) cyc();
    chk("ready_seen", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20 && !done; k++) cyc();
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_counts", {err_count, written_count}, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Register form; tuple offered while IDLE must not be consumed early
    drive(1'b0, 1'b1, 6'h01, 4'd2, 4'd3, 4'd5, 1'b1, 5'd4, 16'h0000);
    cyc(); cyc();
    chk("idle_no_ready", in_ready, 0);
    chk("idle_no_write", wr_en, 0);
    sb_q.push_back({8'h10, 32'h41239005});
    do_start(8'h10, 8'd1);
    chk("load_busy", busy, 1);
    xfer();
    chk("reg_wr_en", wr_en, 1);
    wait_done();
    chk("reg_written", written_count, 1);
    chk("reg_err", err, 0);
    cyc();
    chk("done_one_cycle", done, 0);

    // Immediate form, illegal tuples, and start ignored mid-run
    do_start(8'h20, 8'd4);
    sb_q.push_back({8'h20, 32'hB84000FF});
    drive(1'b1, 1'b0, 6'h38, 4'd4, 4'd4, 4'd0, 1'b0, 5'd0, 16'h00FF);
    xfer();
    start = 1'b1; base_addr = 8'h99; num_instr = 8'd7;
    cyc();
    start = 1'b0;
    drive(1'b1, 1'b0, 6'h38, 4'd4, 4'd5, 4'd0, 1'b0, 5'd0, 16'h00FF);
    xfer();
    chk("ill_rd_no_write", wr_en, 0);
    chk("ill_rd_err", err, 1);
    chk("ill_rd_count", err_count, 1);
    drive(1'b0, 1'b1, 6'h30, 4'd2, 4'd2, 4'd0, 1'b0, 5'd0, 16'h0000);
    xfer();
    chk("ill_s_no_write", wr_en, 0);
    chk("ill_s_count", err_count, 2);
    sb_q.push_back({8'h21, 32'h3F608001});
    drive(1'b0, 1'b0, 6'h3F, 4'd6, 4'd6, 4'd1, 1'b1, 5'd0, 16'h0000);
    xfer();
    chk("ill_next_addr", wr_addr, 8'h21);
    wait_done();
    chk("ill_written", written_count, 2);
    chk("ill_err_hold", {err, err_count}, {1'b1, 8'd2});
    cyc();

    // Back-to-back with address wrap, in_valid held through DRAIN
    do_start(8'hFE, 8'd3);
    sb_q.push_back({8'hFE, 32'h82171234});
    drive(1'b1, 1'b0, 6'h02, 4'd1, 4'd7, 4'd0, 1'b0, 5'd0, 16'h1234);
    cyc();
    chk("b2b_wr1", wr_en, 1);
    sb_q.push_back({8'hFF, 32'h10307C0A});
    drive(1'b0, 1'b0, 6'h10, 4'd3, 4'd3, 4'hA, 1'b0, 5'h1F, 16'h0000);
    cyc();
    chk("b2b_wr2", wr_en, 1);
    sb_q.push_back({8'h00, 32'hE590BEEF});
    drive(1'b1, 1'b1, 6'h25, 4'd9, 4'd9, 4'd0, 1'b0, 5'd0, 16'hBEEF);
    cyc();
    chk("b2b_wr3", wr_en, 1);
    chk("b2b_wrap_addr", wr_addr, 8'h00);
    chk("b2b_ready_low", in_ready, 0);
    cyc();
    chk("b2b_done_2cyc", done, 1);
    chk("b2b_written", written_count, 3);
    chk("b2b_err", err, 0);
    in_valid = 1'b0;
    cyc();

    // Zero-length run clears the previous counts
    do_start(8'h30, 8'd0);
    chk("zero_done", done, 1);
    chk("zero_ready", in_ready, 0);
    chk("zero_counts", {err, err_count, written_count}, 0);
    cyc();
    chk("zero_done_off", done, 0);
    chk("zero_no_write", wr_en, 0);

    // Reset mid-run after 1 of 3 transfers
    do_start(8'h40, 8'd3);
    sb_q.push_back({8'h40, 32'h80FE0001});
    drive(1'b1, 1'b0, 6'h00, 4'hF, 4'hE, 4'd0, 1'b0, 5'd0, 16'h0001);
    xfer();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {wr_en, in_ready, busy, done, err}, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_cnt", {wr_addr, err_count, written_count}, 0);
    sb_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", {busy, in_ready}, 0);
    sb_q.push_back({8'h50, 32'h80FE0001});
    do_start(8'h50, 8'd1);
    drive(1'b1, 1'b0, 6'h00, 4'hF, 4'hE, 4'd0, 1'b0, 5'd0, 16'h0001);
    xfer();
    wait_done();
    chk("post_rst_written", written_count, 1);
    cyc(); cyc();

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded instruction fields back into 32-bit instruction words and writes them sequentially into instruction memory.
- This is the inverse of the control decoder's field extraction. It is used by the program loader and self-test path to build programs from field tuples.
- A run starts with a start pulse. Field tuples arrive over a valid/ready handshake. Each packed word appears on a registered memory write port.

Parameters:
ADDR_W, 8, width of instruction-memory address and of all run counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run (ignored unless IDLE)
base_addr  input  ADDR_W  first write address, sampled on start
num_instr  input  ADDR_W  tuples to accept this run, sampled on start
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept a tuple
in_I  input  1  immediate-form flag -> bit 31
in_S  input  1  set-flags bit -> bit 30
in_opcode  input  6  opcode -> bits 29:24
in_rn  input  4  first source register -> bits 23:20
in_rd  input  4  destination register
in_rm  input  4  second source register (register form)
in_shift  input  1  shift direction (register form)
in_shift_imm  input  5  shift amount (register form)
in_imm  input  16  immediate (immediate form)
wr_en  output  1  memory write strobe
wr_addr  output  ADDR_W  write address
wr_data  output  32  packed instruction word
busy  output  1  high in LOAD and DRAIN
done  output  1  one-cycle pulse at end of run
err  output  1  sticky: at least one illegal tuple this run
err_count  output  ADDR_W  illegal tuples this run
written_count  output  ADDR_W  words written this run

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including in_ready, wr_en, wr_addr, wr_data, done, err and both counts. Any in-flight write is dropped.
- Packing (one tuple):
  - [31]=I, [30]=S, [29:24]=opcode, [23:20]=rn.
  - [19:16] = rd when opcode[5:4]==2'b00, else 4'b0000.
  - [15:0] = imm when I=1.
  - [15:0] = {shift, shift_imm, 6'b0, rm} when I=0.
- Illegal tuple, either condition:
  - opcode[5:4]!=2'b00 and rd!=rn (rd shares the rn field for these ops).
  - opcode[5:4]==2'b11 and S=1 (memory ops never set flags).
- State IDLE:
  - in_ready=0.
  - start with num_instr!=0: latch base_addr into the address register, latch num_instr into the remaining counter, clear err, err_count and written_count, go to LOAD.
  - start with num_instr==0: clear counts, go to DONE.
- State LOAD:
  - in_ready=1 while remaining!=0.
  - A transfer is the cycle where in_valid and in_ready are both 1. Each transfer decrements remaining.
  - Throughput is one tuple per cycle, back-to-back.
- Legal transfer:
  - Next cycle: wr_en=1, wr_data=packed word, wr_addr=current address.
  - After the write, the address increments and written_count increments.
- Illegal transfer:
  - Consumes a slot of num_instr.
  - No write; the address does not advance.
  - err set and err_count incremented in the next cycle.
- On the transfer that makes remaining reach 0: in_ready drops next cycle and the state goes to DRAIN.
- State DRAIN: the final registered write (if any) is issued this cycle, then go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE. Counts and err hold until the next start.
- wr_en is registered: 1-cycle latency from transfer to write, and it is never asserted in IDLE.
- Address wraps modulo 2^ADDR_W silently.
- start in LOAD, DRAIN or DONE is ignored.
- in_valid while in_ready=0 is ignored; the tuple is not consumed.
- Reset mid-run returns to IDLE immediately; partially written memory is not rolled back.

Test Plan:
- Register form: start, base=0x10, num=1. Tuple I=0, S=1, opcode=0x01, rn=2, rd=3, rm=5, shift=1, shift_imm=4 -> one cycle later wr_en=1, wr_addr=0x10, wr_data=0x41239005. Then done pulse; written_count=1, err=0.
- Immediate form: tuple I=1, S=0, opcode=0x38, rn=rd=4, imm=0x00FF -> wr_data=0xB84000FF.
- Illegal tuple: opcode=0x38, rn=4, rd=5 -> no wr_en, err=1, err_count=1, address unchanged. The next legal tuple is written at the same address.
- Back-to-back with wrap: ADDR_W=8, base=0xFE, num=3, in_valid held high -> writes on 3 consecutive cycles at 0xFE, 0xFF, 0x00. in_ready falls after the 3rd transfer; done follows 2 cycles after the last transfer.
- Zero-length run: num=0 -> done one cycle after start; no wr_en; in_ready stays 0.
- Reset mid-run: assert rst_n=0 after 1 of 3 transfers -> all outputs 0 immediately. After release the state is IDLE and start is accepted again.
